// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 opcode fetch path.
package chip8_pkg;

   localparam int CHIP8_ADDR_W = 14;

   typedef logic [15:0] opcode_t;

   typedef enum logic [2:0] {
      IDLE,
      HI,
      LO,
      DONE,
      PREFETCH
   } fetch_state_t;

endpackage

// File: rtl/chip8_fetch_byte.sv
// Single ROM byte read: loads the address, waits for a settled dready, and
// hands back the byte with a one-cycle done pulse.
module chip8_fetch_byte
   import chip8_pkg::*;
#(
   parameter int ADDR_W = CHIP8_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [7:0]        i_mem_dout,
   input  logic              i_mem_dready,
   output logic [7:0]        o_byte,
   output logic              o_done
);

   logic [ADDR_W-1:0] r_addr;
   logic              r_active;
   logic              r_settled;

   // dready still describes the previous address in the first cycle after a load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr    <= '0;
         r_active  <= 1'b0;
         r_settled <= 1'b0;
      end else if (i_start) begin
         r_addr    <= i_addr;
         r_active  <= 1'b1;
         r_settled <= 1'b0;
      end else if (r_active) begin
         r_settled <= 1'b1;
         if (o_done) r_active <= 1'b0;
      end
   end

   assign o_done     = r_active && r_settled && i_mem_dready;
   assign o_byte     = i_mem_dout;
   assign o_mem_addr = r_addr;

endmodule

// File: rtl/chip8_fetch.sv
// CHIP-8 opcode fetch: two big-endian ROM byte reads per opcode, one-cycle valid.
// Optional next-opcode prefetch buffer enabled by defining CHIP8_FETCH_PREFETCH_EN.
module chip8_fetch
   import chip8_pkg::*;
#(
   parameter int ADDR_W = CHIP8_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic [15:0]       opcode,
   output logic              valid,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_dout,
   input  logic              mem_dready
);

   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [7:0]        r_hi;
   opcode_t           r_opcode;
   logic              r_valid;
   logic              r_busy;

   logic              w_start;
   logic [ADDR_W-1:0] w_start_addr;
   logic              w_demand;
   logic              w_done;
   logic [7:0]        w_byte;
`ifdef CHIP8_FETCH_PREFETCH_EN
   opcode_t           r_pbuf;
   logic [ADDR_W-1:0] r_pbuf_addr;
   logic              r_pbuf_valid;
   logic              r_pf_lo;
   logic              r_pf_pend;
   logic              w_hit;
`endif

   chip8_fetch_byte #(.ADDR_W(ADDR_W)) u_byte (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (w_start),
      .i_addr       (w_start_addr),
      .o_mem_addr   (mem_addr),
      .i_mem_dout   (mem_dout),
      .i_mem_dready (mem_dready),
      .o_byte       (w_byte),
      .o_done       (w_done)
   );

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_start      = 1'b0;
      w_start_addr = pc;
      w_demand     = 1'b0;
`ifdef CHIP8_FETCH_PREFETCH_EN
      w_hit        = 1'b0;
`endif
      case (r_state)
         IDLE: begin
`ifdef CHIP8_FETCH_PREFETCH_EN
            w_hit    = req && r_pbuf_valid && (pc == r_pbuf_addr);
            w_demand = req && !w_hit;
`else
            w_demand = req;
`endif
         end
         DONE: begin
`ifdef CHIP8_FETCH_PREFETCH_EN
            // A req for the next sequential opcode joins the prefetch launched here.
            w_hit        = req && (pc == r_pc + ADDR_W'(2));
            w_demand     = req && !w_hit;
            w_start      = 1'b1;
            w_start_addr = r_pc + ADDR_W'(2);
`else
            w_demand = req;
`endif
         end
         HI: begin
            w_start      = w_done;
            w_start_addr = r_pc + ADDR_W'(1);
         end
`ifdef CHIP8_FETCH_PREFETCH_EN
         PREFETCH: begin
            w_hit        = r_pf_pend || (req && (pc == r_pbuf_addr));
            w_demand     = req && !r_pf_pend && (pc != r_pbuf_addr);
            w_start      = w_done && !r_pf_lo;
            w_start_addr = r_pbuf_addr + ADDR_W'(1);
         end
`endif
         default: ;
      endcase
      if (w_demand) begin
         w_start      = 1'b1;
         w_start_addr = pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_pc         <= '0;
         r_hi         <= '0;
         r_opcode     <= '0;
         r_valid      <= 1'b0;
         r_busy       <= 1'b0;
`ifdef CHIP8_FETCH_PREFETCH_EN
         r_pbuf       <= '0;
         r_pbuf_addr  <= '0;
         r_pbuf_valid <= 1'b0;
         r_pf_lo      <= 1'b0;
         r_pf_pend    <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         if (w_demand) begin
            r_pc    <= pc;
            r_busy  <= 1'b1;
            r_state <= HI;
`ifdef CHIP8_FETCH_PREFETCH_EN
            r_pbuf_valid <= 1'b0;
            r_pf_pend    <= 1'b0;
`endif
         end else begin
            case (r_state)
               IDLE: begin
`ifdef CHIP8_FETCH_PREFETCH_EN
                  if (w_hit) begin
                     r_opcode     <= r_pbuf;
                     r_valid      <= 1'b1;
                     r_pc         <= pc;
                     r_pbuf_valid <= 1'b0;
                     r_state      <= DONE;
                  end
`endif
               end
               HI: if (w_done) begin
                  r_hi    <= w_byte;
                  r_state <= LO;
               end
               LO: if (w_done) begin
                  r_opcode <= {r_hi, w_byte};
                  r_valid  <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= DONE;
               end
               DONE: begin
`ifdef CHIP8_FETCH_PREFETCH_EN
                  r_pbuf_addr <= r_pc + ADDR_W'(2);
                  r_pf_lo     <= 1'b0;
                  r_pf_pend   <= w_hit;
                  r_busy      <= w_hit;
                  r_state     <= PREFETCH;
`else
                  r_state <= IDLE;
`endif
               end
`ifdef CHIP8_FETCH_PREFETCH_EN
               PREFETCH: begin
                  if (w_hit) begin
                     r_pf_pend <= 1'b1;
                     r_busy    <= 1'b1;
                  end
                  // NOTE: the last non-blocking assignment wins, so delivery below clears the pending flags set above.
                  if (w_done && !r_pf_lo) begin
                     r_pbuf[15:8] <= w_byte;
                     r_pf_lo      <= 1'b1;
                  end else if (w_done && w_hit) begin
                     r_opcode  <= {r_pbuf[15:8], w_byte};
                     r_valid   <= 1'b1;
                     r_busy    <= 1'b0;
                     r_pf_pend <= 1'b0;
                     r_pc      <= r_pbuf_addr;
                     r_state   <= DONE;
                  end else if (w_done) begin
                     r_pbuf[7:0]  <= w_byte;
                     r_pbuf_valid <= 1'b1;
                     r_state      <= IDLE;
                  end
               end
`endif
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign busy   = r_busy;
   assign opcode = r_opcode;
   assign valid  = r_valid;

endmodule
